// File: rtl/key_event_decoder.sv
// Debounced push-button decoder: clean level plus press/release/long/repeat pulses.
// Define KEY_REPEAT_EN to build the auto-repeat counter; otherwise repeat_pulse is tied 0.
module key_event_decoder #(
    parameter int STABLE_N     = 3,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter int CW           = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        LONG_HELD  = 3'd3,
        RELEASE_DB = 3'd4
    } state_t;

    localparam logic [CW-1:0] ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_N);
    localparam logic [CW-1:0] LONG_C   = CW'(LONG_TICKS);

    if (STABLE_N < 1 || LONG_TICKS < 1 || REPEAT_TICKS < 1 ||
        STABLE_N >= (1 << CW) || LONG_TICKS >= (1 << CW) || REPEAT_TICKS >= (1 << CW)) begin : g_param_check
        $error("key_event_decoder: tick parameters out of range");
    end

    state_t        state_r;
    logic          key_meta_r;
    logic          key_s_r;
    logic          was_long_r;
    logic [CW-1:0] db_cnt_r;
    logic [CW-1:0] hold_cnt_r;
    logic [CW-1:0] db_inc_s;
    logic [CW-1:0] hold_inc_s;

    assign db_inc_s   = db_cnt_r + ONE;
    assign hold_inc_s = hold_cnt_r + ONE;

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] REP_C = CW'(REPEAT_TICKS);
    logic [CW-1:0] rep_cnt_r;
    logic [CW-1:0] rep_inc_s;
    assign rep_inc_s = rep_cnt_r + ONE;
`else
    assign repeat_pulse = 1'b0;
`endif

    // Two-flop synchronizer; presets to released so reset never looks like a press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_meta_r <= 1'b1;
            key_s_r    <= 1'b1;
        end else begin
            key_meta_r <= key_n;
            key_s_r    <= key_meta_r;
        end
    end

    // Debounce / hold state machine with registered level and event pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= IDLE;
            was_long_r    <= 1'b0;
            db_cnt_r      <= ZERO;
            hold_cnt_r    <= ZERO;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt_r     <= ZERO;
            repeat_pulse  <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            if (tick) begin
                case (state_r)
                    IDLE: begin
                        if (!key_s_r) begin
                            if (STABLE_N == 1) begin
                                state_r     <= HELD;
                                pressed     <= 1'b1;
                                press_pulse <= 1'b1;
                                hold_cnt_r  <= ZERO;
                            end else begin
                                state_r  <= PRESS_DB;
                                db_cnt_r <= ONE;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (key_s_r) begin
                            state_r  <= IDLE;
                            db_cnt_r <= ZERO;
                        end else if (db_inc_s == STABLE_C) begin
                            state_r     <= HELD;
                            pressed     <= 1'b1;
                            press_pulse <= 1'b1;
                            db_cnt_r    <= ZERO;
                            hold_cnt_r  <= ZERO;
                        end else begin
                            db_cnt_r <= db_inc_s;
                        end
                    end
                    HELD, LONG_HELD: begin
                        if (key_s_r) begin
                            if (STABLE_N == 1) begin
                                state_r       <= IDLE;
                                pressed       <= 1'b0;
                                release_pulse <= 1'b1;
                                hold_cnt_r    <= ZERO;
`ifdef KEY_REPEAT_EN
                                rep_cnt_r     <= ZERO;
`endif
                            end else begin
                                state_r    <= RELEASE_DB;
                                db_cnt_r   <= ONE;
                                was_long_r <= (state_r == LONG_HELD);
                            end
                        end else if (state_r == HELD) begin
                            if (hold_inc_s == LONG_C) begin
                                state_r    <= LONG_HELD;
                                long_pulse <= 1'b1;
                                hold_cnt_r <= ZERO;
`ifdef KEY_REPEAT_EN
                                rep_cnt_r  <= ZERO;
`endif
                            end else begin
                                hold_cnt_r <= hold_inc_s;
                            end
                        end else begin
`ifdef KEY_REPEAT_EN
                            if (rep_inc_s == REP_C) begin
                                repeat_pulse <= 1'b1;
                                rep_cnt_r    <= ZERO;
                            end else begin
                                rep_cnt_r <= rep_inc_s;
                            end
`endif
                        end
                    end
                    RELEASE_DB: begin
                        // A bounce back to pressed resumes the frozen hold/repeat progress.
                        if (!key_s_r) begin
                            state_r  <= was_long_r ? LONG_HELD : HELD;
                            db_cnt_r <= ZERO;
                        end else if (db_inc_s == STABLE_C) begin
                            state_r       <= IDLE;
                            pressed       <= 1'b0;
                            release_pulse <= 1'b1;
                            db_cnt_r      <= ZERO;
                            hold_cnt_r    <= ZERO;
                            was_long_r    <= 1'b0;
`ifdef KEY_REPEAT_EN
                            rep_cnt_r     <= ZERO;
`endif
                        end else begin
                            db_cnt_r <= db_inc_s;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        pressed  <= 1'b0;
                        db_cnt_r <= ZERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed self-checking bench for key_event_decoder (STABLE_N=3, LONG_TICKS=5, REPEAT_TICKS=2).
module tb_key_event_decoder;

    logic clk;
    logic rstn;
    logic tick;
    logic key_n;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;

    int n_cmp;
    int n_err;
    int n_press;
    int n_release;
    int n_long;
    int n_repeat;
    int tick_no;

`ifdef KEY_REPEAT_EN
    localparam logic REP = 1'b1;
    localparam int   EXP_REPEATS = 2;
`else
    localparam logic REP = 1'b0;
    localparam int   EXP_REPEATS = 0;
`endif

    key_event_decoder #(
        .STABLE_N    (3),
        .LONG_TICKS  (5),
        .REPEAT_TICKS(2),
        .CW          (8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .tick         (tick),
        .key_n        (key_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (press_pulse   === 1'b1) n_press++;
        if (release_pulse === 1'b1) n_release++;
        if (long_pulse    === 1'b1) n_long++;
        if (repeat_pulse  === 1'b1) n_repeat++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {pressed, press_pulse, release_pulse, long_pulse, repeat_pulse};
    endfunction

    // One sample period: hold key_n, let the synchronizer settle, then strobe tick once.
    // exp = {pressed, press, release, long, repeat} one clock after the tick edge.
    task automatic tk(input logic k, input logic [4:0] exp, input string tag);
        key_n = k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
        tick_no++;
        check_eq($sformatf("%s t%0d", tag, tick_no), {27'd0, outs()}, {27'd0, exp});
    endtask

    // One-clock low glitch on key_n that has cleared the synchronizer before the tick.
    task automatic glitch(input string tag);
        key_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        key_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
        check_eq(tag, {27'd0, outs()}, 32'd0);
    endtask

    // Safety net in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; tick_no = 0;
        n_press = 0; n_release = 0; n_long = 0; n_repeat = 0;
        rstn  = 1'b0;
        tick  = 1'b0;
        key_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset outs", {27'd0, outs()}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post-reset outs", {27'd0, outs()}, 32'd0);

        // Key held low but no tick: nothing may happen.
        key_n = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("no-tick press", n_press, 0);
        check_eq("no-tick pressed", {31'd0, pressed}, 32'd0);

        // Clean press, then hold/bounce in HELD; hold count must resume after the bounce.
        tick_no = 0;
        tk(1'b0, 5'b00000, "t1");
        tk(1'b0, 5'b00000, "t1");
        tk(1'b0, 5'b11000, "t1 press");
        tk(1'b0, 5'b10000, "resume");
        tk(1'b0, 5'b10000, "resume");
        tk(1'b1, 5'b10000, "resume bounce");
        tk(1'b1, 5'b10000, "resume bounce");
        tk(1'b0, 5'b10000, "resume back");
        tk(1'b0, 5'b10000, "resume");
        tk(1'b0, 5'b10000, "resume");
        tk(1'b0, 5'b10010, "resume long");
        tk(1'b1, 5'b10000, "long rel");
        tk(1'b1, 5'b10000, "long rel");
        tk(1'b1, 5'b00100, "long rel release");

        // Press bounce: low 2, high 1, low 3.
        tick_no = 0;
        tk(1'b0, 5'b00000, "t2");
        tk(1'b0, 5'b00000, "t2");
        tk(1'b1, 5'b00000, "t2");
        tk(1'b0, 5'b00000, "t2");
        tk(1'b0, 5'b00000, "t2");
        tk(1'b0, 5'b11000, "t2 press");

        // Release bounce from HELD: high 2, low 1, high 3.
        tick_no = 0;
        tk(1'b1, 5'b10000, "t4");
        tk(1'b1, 5'b10000, "t4");
        tk(1'b0, 5'b10000, "t4");
        tk(1'b1, 5'b10000, "t4");
        tk(1'b1, 5'b10000, "t4");
        tk(1'b1, 5'b00100, "t4 release");

        // Long hold: press at 3, long at 8, repeats at 10 and 12.
        tick_no = 0;
        tk(1'b0, 5'b00000, "t3");
        tk(1'b0, 5'b00000, "t3");
        tk(1'b0, 5'b11000, "t3 press");
        for (int i = 4; i <= 7; i++) tk(1'b0, 5'b10000, "t3 hold");
        tk(1'b0, 5'b10010, "t3 long");
        tk(1'b0, 5'b10000, "t3");
        tk(1'b0, {4'b1000, REP}, "t3 repeat");
        tk(1'b0, 5'b10000, "t3");
        tk(1'b0, {4'b1000, REP}, "t3 repeat");

        // Asynchronous reset in LONG_HELD with key still down.
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_eq("t5 async outs", {27'd0, outs()}, 32'd0);
        repeat (2) @(negedge clk);
        check_eq("t5 no release", n_release, 2);
        rstn = 1'b1;
        tick_no = 0;
        tk(1'b0, 5'b00000, "t5");
        tk(1'b0, 5'b00000, "t5");
        tk(1'b0, 5'b11000, "t5 repress");
        tk(1'b1, 5'b10000, "t5");
        tk(1'b1, 5'b10000, "t5");
        tk(1'b1, 5'b00100, "t5 release");

        // Glitches that never reach a sampled edge must leave IDLE untouched.
        for (int i = 0; i < 4; i++) glitch($sformatf("t6 glitch %0d", i));
        tick_no = 0;
        tk(1'b0, 5'b00000, "t6");
        tk(1'b0, 5'b00000, "t6");
        tk(1'b0, 5'b11000, "t6 press");
        tk(1'b1, 5'b10000, "t6");
        tk(1'b1, 5'b10000, "t6");
        tk(1'b1, 5'b00100, "t6 release");

        repeat (2) @(negedge clk);
        check_eq("total press", n_press, 5);
        check_eq("total release", n_release, 4);
        check_eq("total long", n_long, 2);
        check_eq("total repeat", n_repeat, EXP_REPEATS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
